// File: rtl/zx_clk_pkg.sv
// zx_clk_pkg: shared constants and helpers for the Spectrum clock-enable generator.
//
// Contents:
//   CLK_SYS_HZ       nominal clk_sys frequency (112 MHz)
//   LEVEL_3M5        turbo level that gives the stock 3.5 MHz CPU clock
//   DEF_*            default generator parameters
//   SETTLE_W         width of the settle counter (SETTLE is 1..7)
//   level_w()        width of a turbo level field for a given level count
//   lvl_mask()       CPU period minus one, in clk_sys, for a turbo level
//   lvl_half()       CPU half period, in clk_sys, for a turbo level
package zx_clk_pkg;

   localparam int unsigned CLK_SYS_HZ     = 112_000_000;
   localparam int unsigned LEVEL_3M5      = 0;

   localparam int unsigned DEF_CNT_W      = 6;
   localparam int unsigned DEF_LEVELS     = 5;
   localparam int unsigned DEF_SETTLE     = 2;
   localparam int unsigned DEF_FAST_LEVEL = 2;

   localparam int unsigned SETTLE_W       = 3;

   // At least one bit, so a single-level build still has a legal port.
   function automatic int unsigned level_w(input int unsigned levels);
      return (levels > 1) ? $clog2(levels) : 1;
   endfunction

   // Level k runs with a period of 2^(levels-k) clk_sys.
   function automatic int unsigned lvl_mask(input int unsigned levels,
                                            input int unsigned level);
      return (32'd1 << (levels - level)) - 32'd1;
   endfunction

   function automatic int unsigned lvl_half(input int unsigned levels,
                                            input int unsigned level);
      return 32'd1 << (levels - level - 1);
   endfunction

endpackage

// File: rtl/zx_ce_phase.sv
// zx_ce_phase: raw CPU phase decode from the master divider.
//
// The CPU p phase fires when the low bits of the counter (selected by the
// level mask) are all zero; the n phase fires half a period later.
//
// Ports:
//   cnt_i    master divider value
//   level_i  turbo level in effect (already clamped to LEVELS-1)
//   tp_o     raw CPU positive phase for this counter value
//   tn_o     raw CPU negative phase for this counter value
module zx_ce_phase
   import zx_clk_pkg::*;
#(
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned LEVELS  = DEF_LEVELS,
   localparam int unsigned LEVEL_W = level_w(LEVELS)
) (
   input  logic [CNT_W-1:0]   cnt_i,
   input  logic [LEVEL_W-1:0] level_i,
   output logic               tp_o,
   output logic               tn_o
);

   logic [CNT_W-1:0] mask;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] phase;

   always_comb begin
      mask  = CNT_W'(lvl_mask(LEVELS, 32'(level_i)));
      half  = CNT_W'(lvl_half(LEVELS, 32'(level_i)));
      phase = cnt_i & mask;
      tp_o  = (phase == '0);
      tn_o  = (phase == half);
   end

endmodule

// File: rtl/zx_cpu_ce_gen.sv
// zx_cpu_ce_gen: clock-enable generator for the Spectrum core on clk_sys.
//
// A free-running master divider produces the fixed system enables (28 MHz,
// 7 MHz p/n, PSG) and, via the current turbo level, the CPU p/n enables.
// CPU enables are gated by cpu_en, which only changes right after an n slot,
// so every emitted p pulse is always followed by its n pulse.
//
// Optional feature macro: ZX_CE_CONTENTION_EN
//   When defined, the hold input exists; hold=1 on a cycle where the raw CPU
//   p phase is decoded masks that p pulse and the following n pulse.
//
// Ports:
//   clk_sys    system clock (112 MHz nominal)
//   reset      synchronous, active-high reset
//   turbo_sel  requested turbo level (clamped to LEVELS-1)
//   ram_ready  SDRAM ready
//   hold       contention stretch request (ZX_CE_CONTENTION_EN only)
//   ce_28m     pulse every 4 clk_sys
//   ce_7mp     7 MHz positive phase
//   ce_7mn     7 MHz negative phase
//   ce_psg     PSG enable, once per divider wrap
//   ce_cpu_p   gated CPU positive phase
//   ce_cpu_n   gated CPU negative phase
//   ce_cpu     alias of ce_cpu_p
//   cpu_en     CPU running
//   turbo_cur  turbo level in effect
module zx_cpu_ce_gen
   import zx_clk_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned LEVELS     = DEF_LEVELS,
   parameter int unsigned SETTLE     = DEF_SETTLE,
   parameter int unsigned FAST_LEVEL = DEF_FAST_LEVEL,
   localparam int unsigned LEVEL_W   = level_w(LEVELS)
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [LEVEL_W-1:0] turbo_sel,
   input  logic               ram_ready,
`ifdef ZX_CE_CONTENTION_EN
   input  logic               hold,
`endif
   output logic               ce_28m,
   output logic               ce_7mp,
   output logic               ce_7mn,
   output logic               ce_psg,
   output logic               ce_cpu_p,
   output logic               ce_cpu_n,
   output logic               ce_cpu,
   output logic               cpu_en,
   output logic [LEVEL_W-1:0] turbo_cur
);

   localparam logic [LEVEL_W-1:0]  MAX_LEVEL   = LEVEL_W'(LEVELS - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE);

   if ((CNT_W < 4) || (CNT_W < LEVELS)) begin : g_bad_cnt_w
      $error("zx_cpu_ce_gen: CNT_W must be >= max(4, LEVELS)");
   end
   if ((SETTLE < 1) || (SETTLE > 7)) begin : g_bad_settle
      $error("zx_cpu_ce_gen: SETTLE must be in 1..7");
   end

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ce_28m_q, ce_7mp_q, ce_7mn_q, ce_psg_q;
   logic                tp_q, tn_q;
   logic                cpu_en_q, cpu_en_d;
   logic [LEVEL_W-1:0]  turbo_q, turbo_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [LEVEL_W-1:0]  sel_clamped;
   logic                tp_raw, tn_raw;
   logic                gate;

   zx_ce_phase #(
      .CNT_W  (CNT_W),
      .LEVELS (LEVELS)
   ) u_phase (
      .cnt_i   (cnt_q),
      .level_i (turbo_q),
      .tp_o    (tp_raw),
      .tn_o    (tn_raw)
   );

   always_comb begin
      cnt_d       = cnt_q + CNT_W'(1);
      sel_clamped = (turbo_sel > MAX_LEVEL) ? MAX_LEVEL : turbo_sel;
   end

   // Control only moves in the cycle the (current level) n pulse is on the
   // outputs; that n pulse still sees the old cpu_en, which closes any
   // T-state already started.
   always_comb begin
      cpu_en_d = cpu_en_q;
      turbo_d  = turbo_q;
      settle_d = settle_q;
      if (tn_q) begin
         if (sel_clamped != turbo_q) begin
            cpu_en_d = 1'b0;
            turbo_d  = sel_clamped;
            settle_d = SETTLE_INIT;
         end else if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
         end else if (!cpu_en_q && ram_ready) begin
            cpu_en_d = 1'b1;
         end else if ((32'(turbo_q) >= FAST_LEVEL) && !ram_ready) begin
            cpu_en_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q    <= '0;
         ce_28m_q <= 1'b0;
         ce_7mp_q <= 1'b0;
         ce_7mn_q <= 1'b0;
         ce_psg_q <= 1'b0;
         tp_q     <= 1'b0;
         tn_q     <= 1'b0;
         cpu_en_q <= 1'b0;
         turbo_q  <= '0;
         settle_q <= SETTLE_INIT;
      end else begin
         cnt_q    <= cnt_d;
         ce_28m_q <= (cnt_q[1:0] == 2'd0);
         ce_7mp_q <= (cnt_q[3:0] == 4'd0);
         ce_7mn_q <= (cnt_q[3:0] == 4'd8);
         ce_psg_q <= (cnt_q == '0);
         tp_q     <= tp_raw;
         tn_q     <= tn_raw;
         cpu_en_q <= cpu_en_d;
         turbo_q  <= turbo_d;
         settle_q <= settle_d;
      end
   end

`ifdef ZX_CE_CONTENTION_EN
   logic gate_q, gate_d;

   // Sampled once per T-state at the raw p decode and held through the
   // matching n slot, so p and n are always masked as a pair.
   always_comb begin
      gate_d = tp_raw ? ~hold : gate_q;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         gate_q <= 1'b1;
      end else begin
         gate_q <= gate_d;
      end
   end

   assign gate = gate_q;
`else
   assign gate = 1'b1;
`endif

   assign ce_28m    = ce_28m_q;
   assign ce_7mp    = ce_7mp_q;
   assign ce_7mn    = ce_7mn_q;
   assign ce_psg    = ce_psg_q;
   assign ce_cpu_p  = cpu_en_q & tp_q & gate;
   assign ce_cpu_n  = cpu_en_q & tn_q & gate;
   assign ce_cpu    = ce_cpu_p;
   assign cpu_en    = cpu_en_q;
   assign turbo_cur = turbo_q;

endmodule

// File: tb/tb_zx_cpu_ce_gen.sv
// tb_zx_cpu_ce_gen: directed bench for zx_cpu_ce_gen at default parameters.
// Index n counts clk_sys edges since reset release; samples are taken 1 time
// unit after each rising edge, so "after edge n" is what each check sees.
module tb_zx_cpu_ce_gen;

   localparam int SETTLE = 2;

   typedef struct {
      logic [2:0] sel;
      int         cur;
      int         period;
   } vec_t;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] turbo_sel = 3'd0;
   logic       ram_ready = 1'b1;
`ifdef ZX_CE_CONTENTION_EN
   logic       hold = 1'b0;
`endif
   logic       ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en;
   logic [2:0] turbo_cur;

   int tests = 0;
   int fails = 0;
   int n = 0;

   always #5 clk_sys = ~clk_sys;

   zx_cpu_ce_gen dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .turbo_sel (turbo_sel),
      .ram_ready (ram_ready),
`ifdef ZX_CE_CONTENTION_EN
      .hold      (hold),
`endif
      .ce_28m    (ce_28m),
      .ce_7mp    (ce_7mp),
      .ce_7mn    (ce_7mn),
      .ce_psg    (ce_psg),
      .ce_cpu_p  (ce_cpu_p),
      .ce_cpu_n  (ce_cpu_n),
      .ce_cpu    (ce_cpu),
      .cpu_en    (cpu_en),
      .turbo_cur (turbo_cur)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
      n++;
   endtask

   task automatic wait_p(output int idx);
      idx = -1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (ce_cpu_p) begin
            idx = n;
            break;
         end
      end
   endtask

   task automatic wait_n(output int idx);
      idx = -1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (ce_cpu_n) begin
            idx = n;
            break;
         end
      end
   endtask

   // First gated p after the n slot at index k in which turbo_sel was changed.
   function automatic int exp_first_p(input int k, input int period, input bit same);
      int j;
      if (same) begin
         j = k + 1;
         while (j % period != 0) j++;
         return j;
      end
      j = k + 2;
      while (j % period != period / 2) j++;
      return j + SETTLE * period + period / 2;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal;
   end

   initial begin
      vec_t vecs[6];
      int   e28, e7p, e7n, epsg, ealias, p1, p2, n1, en1;
      int   k, pa, na, pb, exp_pa, prev_cur, cnt, pc, nc, lows;
      bit   same;

      vecs[0] = '{3'd2, 2, 8};
      vecs[1] = '{3'd7, 4, 2};
      vecs[2] = '{3'd5, 4, 2};
      vecs[3] = '{3'd1, 1, 16};
      vecs[4] = '{3'd3, 3, 4};
      vecs[5] = '{3'd0, 0, 32};

      // Reset values and start-up
      repeat (3) step();
      check("reset_outputs", int'({ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n,
                                   ce_cpu, cpu_en}), 0);
      check("reset_turbo_cur", int'(turbo_cur), 0);
      reset = 1'b0;
      n = -1;
      e28 = 0; e7p = 0; e7n = 0; epsg = 0; ealias = 0;
      p1 = -1; p2 = -1; n1 = -1; en1 = -1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (ce_28m != (n % 4 == 0)) e28++;
         if (ce_7mp != (n % 16 == 0)) e7p++;
         if (ce_7mn != (n % 16 == 8)) e7n++;
         if (ce_psg != (n % 64 == 0)) epsg++;
         if (ce_cpu != ce_cpu_p) ealias++;
         if (cpu_en && en1 < 0) en1 = n;
         if (ce_cpu_p) begin
            if (p1 < 0) p1 = n;
            else if (p2 < 0) p2 = n;
         end
         if (ce_cpu_n && n1 < 0) n1 = n;
      end
      check("ce_28m_pattern_errors", e28, 0);
      check("ce_7mp_pattern_errors", e7p, 0);
      check("ce_7mn_pattern_errors", e7n, 0);
      check("ce_psg_pattern_errors", epsg, 0);
      check("ce_cpu_alias_errors", ealias, 0);
      check("startup_cpu_en_index", en1, 81);
      check("startup_first_p", p1, 96);
      check("startup_first_n", n1, 112);
      check("startup_second_p", p2, 128);

      // Level table: change level right after an observed n pulse
      wait_n(k);
      prev_cur = 0;
      for (int r = 0; r < 6; r++) begin
         same = (vecs[r].cur == prev_cur);
         exp_pa = exp_first_p(k, vecs[r].period, same);
         turbo_sel = vecs[r].sel;
         wait_p(pa);
         wait_n(na);
         wait_p(pb);
         check($sformatf("vec%0d_first_p", r), pa, exp_pa);
         check($sformatf("vec%0d_turbo_cur", r), int'(turbo_cur), vecs[r].cur);
         check($sformatf("vec%0d_period", r), pb - pa, vecs[r].period);
         check($sformatf("vec%0d_p_to_n", r), na - pa, vecs[r].period / 2);
         wait_n(k);
         prev_cur = vecs[r].cur;
      end

      // Level 3: ram_ready low stops the CPU
      turbo_sel = 3'd3;
      wait_p(pa);
      wait_n(k);
      ram_ready = 1'b0;
      step();
      check("l3_cpu_en_drop", int'(cpu_en), 0);
      cnt = int'(ce_cpu_p) + int'(ce_cpu_n);
      while (n < k + 20) begin
         step();
         cnt += int'(ce_cpu_p) + int'(ce_cpu_n);
      end
      ram_ready = 1'b1;
      step();
      cnt += int'(ce_cpu_p) + int'(ce_cpu_n);
      check("l3_pulses_while_stalled", cnt, 0);
      check("l3_cpu_en_reenable", int'(cpu_en), 1);
      step();
      check("l3_first_p_after_ready", int'(ce_cpu_p), 1);

      // Level 1: ram_ready low does not stop a running CPU
      wait_n(k);
      turbo_sel = 3'd1;
      wait_p(pa);
      wait_n(k);
      ram_ready = 1'b0;
      pc = 0; nc = 0; lows = 0;
      while (n < k + 20) begin
         step();
         pc += int'(ce_cpu_p);
         nc += int'(ce_cpu_n);
         if (!cpu_en) lows++;
      end
      ram_ready = 1'b1;
      check("l1_cpu_en_low_cycles", lows, 0);
      check("l1_p_pulses", pc, 1);
      check("l1_n_pulses", nc, 1);

      // Reset mid-stream at the top level
      wait_n(k);
      turbo_sel = 3'd7;
      wait_p(pa);
      wait_n(k);
      check("l4_turbo_cur", int'(turbo_cur), 4);
      reset = 1'b1;
      step();
      check("midreset_outputs", int'({ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n,
                                      ce_cpu, cpu_en}), 0);
      check("midreset_turbo_cur", int'(turbo_cur), 0);
      turbo_sel = 3'd0;
      reset = 1'b0;
      n = -1;
      wait_p(pa);
      check("rerelease_first_p", pa, 96);

`ifdef ZX_CE_CONTENTION_EN
      // Contention: hold during the raw p decode drops one whole T-state
      wait_n(k);
      while (n < k + 15) step();
      hold = 1'b1;
      step();
      hold = 1'b0;
      cnt = int'(ce_cpu_p) + int'(ce_cpu_n);
      while (n < k + 47) begin
         step();
         cnt += int'(ce_cpu_p) + int'(ce_cpu_n);
      end
      check("hold_masked_pulses", cnt, 0);
      wait_p(pa);
      check("hold_next_p", pa, k + 48);
      wait_n(na);
      check("hold_next_n", na, k + 64);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/zx_cpu_ce_gen.md
Name: zx_cpu_ce_gen

Overview:
Parametrised clock-enable generator for the Spectrum core, running entirely on clk_sys (112 MHz nominal).
- Produces the fixed system enables: 28 MHz, 7 MHz p/n phases and PSG 1.75 MHz.
- Produces a CPU enable pair (p/n) whose rate is one of LEVELS turbo levels.
- Switches turbo level glitch-free, with a settle pause between levels.
- Stalls the CPU on slow RAM at high turbo levels.
- Sits between the top level and T80pa/wd1793/smart_tape. It replaces the ad-hoc counter/turbo logic, generalised in level count and settle length.

Parameters:
- CNT_W, 6, master divider width; ce_psg period = 2^CNT_W clk_sys; must be >= max(4, LEVELS).
- LEVELS, 5, number of turbo levels; level k CPU period = 2^(LEVELS-k) clk_sys (level 0 = 3.5 MHz at default).
- SETTLE, 2, CPU n-phases with cpu_en held low after a level change or reset (1..7).
- FAST_LEVEL, 2, levels >= this drop cpu_en while ram_ready is low.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- turbo_sel  in  $clog2(LEVELS)  requested level; values > LEVELS-1 clamp to LEVELS-1
- ram_ready  in  1  SDRAM ready
- hold  in  1  contention stretch request (only with CONTENTION_EN)
- ce_28m  out  1  pulse every 4 clk
- ce_7mp  out  1  7 MHz positive phase
- ce_7mn  out  1  7 MHz negative phase
- ce_psg  out  1  PSG enable
- ce_cpu_p  out  1  gated CPU positive phase
- ce_cpu_n  out  1  gated CPU negative phase
- ce_cpu  out  1  alias of ce_cpu_p (for FDC/tape)
- cpu_en  out  1  CPU running
- turbo_cur  out  $clog2(LEVELS)  level in effect

Behaviour:
- Reset values: cnt=0, every ce_* output 0, cpu_en=0, turbo_cur=0, settle=SETTLE.
- cnt free-runs, +1 per clk_sys, wraps at 2^CNT_W.
- All ce outputs are registered and are one cycle behind the decoded cnt value. Decodes:
  - ce_28m: cnt[1:0]==0
  - ce_7mp: cnt[3:0]==0
  - ce_7mn: cnt[3:0]==8
  - ce_psg: cnt==0
- Raw CPU phases, with mask=2^(LEVELS-turbo_cur)-1:
  - tp = (cnt&mask)==0
  - tn = (cnt&mask)==(mask+1)/2
  - tp and tn are never coincident, since period >= 2.
- Gated outputs: ce_cpu_p = cpu_en & tp_reg; ce_cpu_n = cpu_en & tn_reg.
- Control state is updated only on cycles where tn_reg=1 (current level), in this priority order:
  1. Clamped turbo_sel != turbo_cur: cpu_en<=0, turbo_cur<=sel, settle<=SETTLE.
  2. Else if settle != 0: settle<=settle-1.
  3. Else if !cpu_en & ram_ready: cpu_en<=1.
  4. Else if turbo_cur>=FAST_LEVEL & !ram_ready: cpu_en<=0.
- Because cpu_en changes only after an n pulse, every emitted ce_cpu_p is followed by its ce_cpu_n. There are no half T-states.
- A new request arriving during settle restarts settle with the new level. Re-selecting the current level causes no pause.
- Below FAST_LEVEL, ram_ready low does not stop a running CPU; it only blocks the initial enable.
- Reset mid-operation returns all state to reset values on the next edge.

Optional Feature:
- Macro: ZX_CE_CONTENTION_EN.
- With the macro defined:
  - The hold port exists.
  - If hold=1 on a cycle where tp is decoded, that p pulse and the following n pulse are masked, stretching the T-state by one full CPU period.
  - Control updates still occur on masked n slots.
- Without the macro: the hold port is absent and no masking occurs.

Decomposition:
- Package zx_clk_pkg holds:
  - the LEVEL_W localparam function;
  - functions lvl_mask(level) and lvl_half(level);
  - the default constants (112 MHz base, LEVEL_3M5=0).
- Single module. A small zx_ce_phase sub-module (tp/tn decode from cnt and level) is permitted but not required.

Test Plan:
- Defaults, reset released, sel=0, ram_ready=1 -> first ce_cpu_p after 2 raw n-phases; then ce_cpu_p every 32 clk with ce_cpu_n 16 clk later; cpu_en=1.
- Free-run check -> ce_28m period 4, ce_psg period 64, ce_7mp/ce_7mn period 16 each, offset 8, never gated by cpu_en.
- Running at level 0, sel 0->2 -> cpu_en low at the next n, turbo_cur=2, no ce_cpu pulses for 2 n-phases of 8 clk, then ce_cpu_p every 8 clk.
- Level 3, ram_ready low 20 clk -> cpu_en drops at the next n and ce_cpu suppressed; re-enabled at the first n after ready. Same stimulus at level 1 -> no gap.
- sel=7 -> turbo_cur=4, ce_cpu_p every 2 clk. Reset asserted mid-stream -> all outputs 0 next cycle, turbo_cur=0.
- ZX_CE_CONTENTION_EN, level 0, hold=1 at one tp -> that p/n pair absent, next pair 32 clk later; no lone p or lone n observed.
